// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the handshaked memory stage: width defaults,
// the data-memory base address and the access FSM state encoding.
package mem_stage_hs_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 32;
  localparam int unsigned DEF_REG_ADDR_W = 4;
  localparam int unsigned DEF_BASE_ADDR  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_hs_if.sv
// Request/acknowledge word-memory bus between the memory stage (master)
// and an external SRAM controller or cache (slave).
interface mem_stage_hs_if
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned MEM_ADDR_W = 9
);
  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_hs_xlate.sv
// Combinational byte-address to word-index translation with alignment
// and range checking against the data-memory window.
module mem_addr_xlate
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned MEM_ADDR_W = 9,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned BASE_ADDR  = DEF_BASE_ADDR
) (
  input  logic [WORD_WIDTH-1:0] alu_res,
  output logic [MEM_ADDR_W-1:0] idx,
  output logic                  mis_align,
  output logic                  out_range
);
  logic [WORD_WIDTH-1:0] off;
  logic [WORD_WIDTH-1:0] word_idx;

  always_comb begin
    off       = alu_res - WORD_WIDTH'(BASE_ADDR);
    word_idx  = off >> 2;
    idx       = word_idx[MEM_ADDR_W-1:0];
    mis_align = (alu_res[1:0] != 2'b00);
    // Below-base addresses wrap to a huge index; the explicit compare keeps intent clear.
    out_range = (alu_res < WORD_WIDTH'(BASE_ADDR)) || (word_idx >= WORD_WIDTH'(DEPTH));
  end
endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline memory stage driving an external word memory over a req/ack
// handshake; stalls the pipeline via freeze until the access completes.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned MEM_ADDR_W = 9,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned BASE_ADDR  = DEF_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] dst,
  input  logic [WORD_WIDTH-1:0] ALU_res,
  input  logic [WORD_WIDTH-1:0] val_Rm,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  WB_en,
  output logic [REG_ADDR_W-1:0] dst_out,
  output logic [WORD_WIDTH-1:0] ALU_res_out,
  output logic                  mem_read_out,
  output logic                  WB_en_out,
  output logic [WORD_WIDTH-1:0] mem_out,
  output logic                  freeze,
  mem_stage_hs_if.master        mem,
  output logic                  err_align,
  output logic                  err_range
);
  state_t                state;
  logic                  done_err;
  logic                  access;
  logic                  mis_align;
  logic                  out_range;
  logic                  illegal;
  logic [MEM_ADDR_W-1:0] idx;

  mem_addr_xlate #(
    .WORD_WIDTH (WORD_WIDTH),
    .MEM_ADDR_W (MEM_ADDR_W),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) u_xlate (
    .alu_res   (ALU_res),
    .idx       (idx),
    .mis_align (mis_align),
    .out_range (out_range)
  );

  always_comb begin
    access       = mem_read | mem_write;
    illegal      = mis_align | out_range;
    dst_out      = dst;
    ALU_res_out  = ALU_res;
    mem_read_out = mem_read;
    freeze       = access && (state != ST_DONE);
    // done_err marks a faulted load; it only matters while DONE is presented to MEM/WB.
    WB_en_out    = WB_en && !((state == ST_DONE) && done_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      done_err      <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem_out       <= '0;
      err_align     <= 1'b0;
      err_range     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (illegal) begin
              err_align <= err_align | mis_align;
              err_range <= err_range | out_range;
              mem_out   <= '0;
              done_err  <= ~mem_write;
              state     <= ST_DONE;
            end else begin
              mem.mem_we    <= mem_write;
              mem.mem_addr  <= idx;
              mem.mem_wdata <= val_Rm;
              mem.mem_req   <= 1'b1;
              done_err      <= 1'b0;
              state         <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) mem_out <= mem.mem_rdata;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized self-checking bench for mem_stage_hs with a wait-state memory
// slave and a transaction-level reference model of the stage.
module tb_mem_stage_hs;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dst;
  logic [31:0] alu_res, val_rm;
  logic        mem_read, mem_write, wb_en;
  logic [3:0]  dst_out;
  logic [31:0] alu_res_out, mem_out;
  logic        mem_read_out, wb_en_out, freeze, err_align, err_range;

  always #5 clk = ~clk;

  mem_stage_hs_if #(.WORD_WIDTH(32), .MEM_ADDR_W(9)) bus ();

  mem_stage_hs #(
    .WORD_WIDTH (32),
    .REG_ADDR_W (4),
    .MEM_ADDR_W (9),
    .DEPTH      (512),
    .BASE_ADDR  (1024)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .dst          (dst),
    .ALU_res      (alu_res),
    .val_Rm       (val_rm),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .WB_en        (wb_en),
    .dst_out      (dst_out),
    .ALU_res_out  (alu_res_out),
    .mem_read_out (mem_read_out),
    .WB_en_out    (wb_en_out),
    .mem_out      (mem_out),
    .freeze       (freeze),
    .mem          (bus),
    .err_align    (err_align),
    .err_range    (err_range)
  );

  // Memory slave: acks in the lat-th cycle that mem_req is seen high.
  logic [31:0] smem [DEPTH] = '{default: '0};
  int unsigned lat = 1;
  int unsigned cnt = 0;
  logic        force_ack = 1'b0;
  logic        nat_ack;

  assign nat_ack       = bus.mem_req && (cnt == lat - 1);
  assign bus.mem_ack   = nat_ack | force_ack;
  assign bus.mem_rdata = force_ack ? 32'hBAD0_BAD0 : smem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_req && !nat_ack) cnt <= cnt + 1;
    else                         cnt <= 0;
    if (nat_ack && bus.mem_we) smem[bus.mem_addr] <= bus.mem_wdata;
  end

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_out;
  logic        exp_ea, exp_er;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      wb_en     = 1'($urandom);
      alu_res   = $urandom;
      #1;
      check("nomem_freeze", 32'(freeze), 32'd0);
      check("nomem_alu_pass", alu_res_out, alu_res);
      @(negedge clk);
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic wb,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int unsigned l);
    logic        mis, oor, legal, is_load, exp_wb;
    int unsigned widx, fcyc, reqcyc;
    mis     = (addr % 4) != 0;
    oor     = (addr < BASE) || (((addr - BASE) / 4) >= DEPTH);
    legal   = !mis && !oor;
    widx    = legal ? (addr - BASE) / 4 : 0;
    is_load = rd && !wr;
    lat       = l;
    dst       = 4'($urandom);
    alu_res   = addr;
    val_rm    = data;
    mem_read  = rd;
    mem_write = wr;
    wb_en     = wb;
    #1;
    check("freeze_rise", 32'(freeze), 32'd1);
    check("dst_pass", 32'(dst_out), 32'(dst));
    check("rd_pass", 32'(mem_read_out), 32'(rd));
    check("wb_idle", 32'(wb_en_out), 32'(wb));
    fcyc   = 0;
    reqcyc = 0;
    while (freeze === 1'b1 && fcyc < 40) begin
      @(negedge clk);
      fcyc++;
      if (bus.mem_req === 1'b1) reqcyc++;
      if (fcyc == 1 && legal) begin
        check("busy_req", 32'(bus.mem_req), 32'd1);
        check("busy_addr", 32'(bus.mem_addr), widx);
        check("busy_we", 32'(bus.mem_we), 32'(wr));
        check("busy_wdata", bus.mem_wdata, data);
      end
    end
    check("occupancy", fcyc, legal ? l + 1 : 1);
    check("req_cycles", reqcyc, legal ? l : 0);
    if (!legal) begin
      exp_out = '0;
      exp_ea  = exp_ea | mis;
      exp_er  = exp_er | oor;
    end else if (wr) begin
      ref_mem[widx] = data;
    end else begin
      exp_out = ref_mem[widx];
    end
    exp_wb = wb && !(!legal && is_load);
    check("done_mem_out", mem_out, exp_out);
    check("done_err_align", 32'(err_align), 32'(exp_ea));
    check("done_err_range", 32'(err_range), 32'(exp_er));
    check("done_wb", 32'(wb_en_out), 32'(exp_wb));
    check("done_req", 32'(bus.mem_req), 32'd0);
    if (legal && wr) check("slave_mem", smem[widx], ref_mem[widx]);
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_mem_out"}, mem_out, 32'd0);
    check({tag, "_err_align"}, 32'(err_align), 32'd0);
    check({tag, "_err_range"}, 32'(err_range), 32'd0);
    check({tag, "_freeze"}, 32'(freeze), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic        r, w;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    exp_out = '0; exp_ea = 1'b0; exp_er = 1'b0;
    rst = 1'b1; dst = '0; alu_res = '0; val_rm = '0;
    mem_read = 1'b0; mem_write = 1'b0; wb_en = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    idle(2);

    // Directed scenarios
    do_access(1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 2);
    do_access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 3);
    check("ldr_deadbeef", mem_out, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h1234_5678, 1);
    do_access(1'b1, 1'b0, 1'b1, 32'd1026, 32'h0, 1);
    do_access(1'b1, 1'b0, 1'b1, 32'd1020, 32'h0, 1);
    do_access(1'b1, 1'b0, 1'b1, BASE + 4 * DEPTH, 32'h0, 1);
    do_access(1'b1, 1'b1, 1'b1, 32'd1024 + 4 * 511, 32'hCAFE_F00D, 2);
    do_access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, 1);
    do_access(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, 1);

    // Spurious ack while idle must be ignored
    mem_read = 1'b0; mem_write = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check("spur_mem_out", mem_out, exp_out);
    check("spur_req", 32'(bus.mem_req), 32'd0);
    idle(1);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
        2:    a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
        default: a = $urandom_range(0, 1) ? ($urandom_range(0, BASE - 1) & ~32'd3)
                                           : BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000);
      endcase
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      do_access(r, w, 1'($urandom), a, $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 2) == 0) idle(1);
    end

    // Reset during BUSY; a late ack afterwards must be ignored
    lat = 10; alu_res = 32'd1032; mem_read = 1'b1; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check_cleared("rst_busy");
    rst = 1'b0; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check("late_ack_mem_out", mem_out, 32'd0);
    check("late_ack_req", 32'(bus.mem_req), 32'd0);
    exp_out = '0; exp_ea = 1'b0; exp_er = 1'b0;
    do_access(1'b1, 1'b0, 1'b1, 32'd1024 + 4 * 511, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
